// File: rtl/i2c_pkg.sv
// Shared FSM encoding and address-byte field positions for the sys_clk I2C slave.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEVADR,
    ACK_DEV,
    PTR,
    ACK_PTR,
    WDATA,
    ACK_W,
    RDATA,
    MACK,
    IGNORE
  } i2c_state_e;

  localparam int   ADR_MSB = 7;
  localparam int   ADR_LSB = 1;
  localparam int   RW_BIT  = 0;
  localparam logic RW_READ = 1'b1;

  function automatic logic adrMatch(input logic [7:0] adrByte, input logic [6:0] devAdr);
    return adrByte[ADR_MSB:ADR_LSB] == devAdr;
  endfunction

endpackage

// File: rtl/i2c_in_filter.sv
// Two-flop synchronizer plus FILT-sample majority-free glitch filter:
// the output only moves once FILT consecutive synced samples agree.
module i2c_in_filter #(
  parameter int FILT = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic in_i,
  output logic filt_o
);

  logic [1:0]      sync_q;
  logic [FILT-1:0] hist_q, hist_d;
  logic            filt_q, filt_d;

  always_comb begin
    hist_d = (hist_q << 1) | FILT'(sync_q[1]);
    filt_d = filt_q;
    if (&hist_q) begin
      filt_d = 1'b1;
    end else if (~|hist_q) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 2'b11;
      hist_q <= '1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], in_i};
      hist_q <= hist_d;
      filt_q <= filt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/i2c_slave_sysclk_nb.sv
// I2C slave bridging to a word-wide RAM, fully oversampled in the sys_clk domain.
// Bytes are packed MSB-first into BYTES-wide words addressed by a persistent pointer.
module i2c_slave_sysclk_nb
  import i2c_pkg::*;
#(
  parameter logic [6:0] I2C_ADR = 7'h27,
  parameter int         BYTES   = 4,
  parameter int         ADDR_W  = 8,
  parameter int         FILT    = 3,
  parameter int         RD_LAT  = 1,
  localparam int        DW      = 8 * BYTES
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              SCL,
  inout  wire               SDA,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DW-1:0]     ram_wr_data_o,
  output logic              ram_rd_en_o,
  output logic [ADDR_W-1:0] ram_rd_addr_o,
  input  logic [DW-1:0]     ram_rd_data_i,
  output logic              busy_o
);

  localparam int             BCW       = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES - 1);

  logic sclF, sdaF;

  i2c_in_filter #(.FILT(FILT)) u_scl_filt (
    .clk_i   (sys_clk_i),
    .rst_n_i (rst_n_i),
    .in_i    (SCL),
    .filt_o  (sclF)
  );

  i2c_in_filter #(.FILT(FILT)) u_sda_filt (
    .clk_i   (sys_clk_i),
    .rst_n_i (rst_n_i),
    .in_i    (SDA),
    .filt_o  (sdaF)
  );

  i2c_state_e        state_q, state_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        shift_q, shift_d;
  logic [BCW-1:0]    byteCnt_q, byteCnt_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]     wrWord_q, wrWord_d;
  logic [DW-1:0]     rdWord_q, rdWord_d;
  logic              rw_q, rw_d;
  logic              busy_q, busy_d;
  logic              sdaOe_q, sdaOe_d;
  logic              wrEn_q, wrEn_d;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [DW-1:0]     wrData_q, wrData_d;
  logic              rdEn_q, rdEn_d;
  logic [ADDR_W-1:0] rdAddr_q, rdAddr_d;
  logic [RD_LAT-1:0] rdPipe_q, rdPipe_d;
  logic              wordDone_q, wordDone_d;
  logic              mackSeen_q, mackSeen_d;
  logic              sclPrev_q, sdaPrev_q;

  logic       sclRise, sclFall, startDet, stopDet;
  logic [7:0] rxByte;
  logic [DW-1:0] rxWord;

  assign sclRise  = sclF & ~sclPrev_q;
  assign sclFall  = ~sclF & sclPrev_q;
  assign startDet = sclF & sclPrev_q & sdaPrev_q & ~sdaF;
  assign stopDet  = sclF & sclPrev_q & ~sdaPrev_q & sdaF;
  assign rxByte   = {shift_q[6:0], sdaF};
  assign rxWord   = (wrWord_q << 8) | DW'(rxByte);

  function automatic logic txBitAt(input logic [DW-1:0] word, input int byteIdx, input int bitIdx);
    logic [DW-1:0] shifted;
    shifted = word << (8 * byteIdx + bitIdx);
    return shifted[DW-1];
  endfunction

  // SDA drive only moves on a filtered SCL fall, except for aborts which only release.
  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    byteCnt_d  = byteCnt_q;
    ptr_d      = ptr_q;
    wrWord_d   = wrWord_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sdaOe_d    = sdaOe_q;
    wrEn_d     = 1'b0;
    wrAddr_d   = wrAddr_q;
    wrData_d   = wrData_q;
    rdEn_d     = 1'b0;
    rdAddr_d   = rdAddr_q;
    wordDone_d = wordDone_q;
    mackSeen_d = mackSeen_q;
    rdPipe_d   = (rdPipe_q << 1) | RD_LAT'(rdEn_q);
    rdWord_d   = rdPipe_q[RD_LAT-1] ? ram_rd_data_i : rdWord_q;

    if (stopDet) begin
      state_d    = IDLE;
      busy_d     = 1'b0;
      sdaOe_d    = 1'b0;
      bitCnt_d   = '0;
      byteCnt_d  = '0;
      wordDone_d = 1'b0;
    end else if (startDet) begin
      state_d    = DEVADR;
      sdaOe_d    = 1'b0;
      bitCnt_d   = '0;
      byteCnt_d  = '0;
      wordDone_d = 1'b0;
    end else begin
      case (state_q)
        DEVADR: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              bitCnt_d = '0;
              if (adrMatch(rxByte, I2C_ADR)) begin
                state_d = ACK_DEV;
                busy_d  = 1'b1;
                rw_d    = rxByte[RW_BIT];
                if (rxByte[RW_BIT] == RW_READ) begin
                  rdEn_d     = 1'b1;
                  rdAddr_d   = ptr_q;
                  byteCnt_d  = '0;
                  wordDone_d = 1'b0;
                end
              end else begin
                state_d = IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end

        // In the ACK states the first fall asserts the ACK, the second ends it.
        ACK_DEV: begin
          if (sclFall) begin
            if (!sdaOe_q) begin
              sdaOe_d = 1'b1;
            end else if (rw_q == RW_READ) begin
              state_d  = RDATA;
              bitCnt_d = '0;
              sdaOe_d  = ~txBitAt(rdWord_q, int'(byteCnt_q), 0);
            end else begin
              state_d  = PTR;
              bitCnt_d = '0;
              sdaOe_d  = 1'b0;
            end
          end
        end

        PTR: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              bitCnt_d  = '0;
              ptr_d     = rxByte[ADDR_W-1:0];
              byteCnt_d = '0;
              state_d   = ACK_PTR;
            end
          end
        end

        ACK_PTR, ACK_W: begin
          if (sclFall) begin
            if (!sdaOe_q) begin
              sdaOe_d = 1'b1;
            end else begin
              state_d  = WDATA;
              bitCnt_d = '0;
              sdaOe_d  = 1'b0;
            end
          end
        end

        WDATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              bitCnt_d = '0;
              wrWord_d = rxWord;
              state_d  = ACK_W;
              if (byteCnt_q == LAST_BYTE) begin
                wrEn_d    = 1'b1;
                wrAddr_d  = ptr_q;
                wrData_d  = rxWord;
                ptr_d     = ptr_q + ADDR_W'(1);
                byteCnt_d = '0;
              end else begin
                byteCnt_d = byteCnt_q + BCW'(1);
              end
            end
          end
        end

        RDATA: begin
          if (sclFall) begin
            if (bitCnt_q == 3'd7) begin
              state_d    = MACK;
              sdaOe_d    = 1'b0;
              bitCnt_d   = '0;
              mackSeen_d = 1'b0;
              if (byteCnt_q == LAST_BYTE) begin
                wordDone_d = 1'b1;
              end else begin
                byteCnt_d = byteCnt_q + BCW'(1);
              end
            end else begin
              bitCnt_d = bitCnt_q + 3'd1;
              sdaOe_d  = ~txBitAt(rdWord_q, int'(byteCnt_q), int'(bitCnt_q) + 1);
            end
          end
        end

        // The pointer advances after a finished word even on NACK; the prefetch
        // is only issued when the master asks for more.
        MACK: begin
          if (sclRise) begin
            if (wordDone_q) begin
              ptr_d      = ptr_q + ADDR_W'(1);
              byteCnt_d  = '0;
              wordDone_d = 1'b0;
            end
            if (sdaF) begin
              state_d = IGNORE;
              busy_d  = 1'b0;
            end else begin
              mackSeen_d = 1'b1;
              if (wordDone_q) begin
                rdEn_d   = 1'b1;
                rdAddr_d = ptr_q + ADDR_W'(1);
              end
            end
          end else if (sclFall && mackSeen_q) begin
            state_d  = RDATA;
            bitCnt_d = '0;
            sdaOe_d  = ~txBitAt(rdWord_q, int'(byteCnt_q), 0);
          end
        end

        IGNORE: begin
          busy_d  = 1'b0;
          sdaOe_d = 1'b0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      byteCnt_q  <= '0;
      ptr_q      <= '0;
      wrWord_q   <= '0;
      rdWord_q   <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sdaOe_q    <= 1'b0;
      wrEn_q     <= 1'b0;
      wrAddr_q   <= '0;
      wrData_q   <= '0;
      rdEn_q     <= 1'b0;
      rdAddr_q   <= '0;
      rdPipe_q   <= '0;
      wordDone_q <= 1'b0;
      mackSeen_q <= 1'b0;
      sclPrev_q  <= 1'b1;
      sdaPrev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      byteCnt_q  <= byteCnt_d;
      ptr_q      <= ptr_d;
      wrWord_q   <= wrWord_d;
      rdWord_q   <= rdWord_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sdaOe_q    <= sdaOe_d;
      wrEn_q     <= wrEn_d;
      wrAddr_q   <= wrAddr_d;
      wrData_q   <= wrData_d;
      rdEn_q     <= rdEn_d;
      rdAddr_q   <= rdAddr_d;
      rdPipe_q   <= rdPipe_d;
      wordDone_q <= wordDone_d;
      mackSeen_q <= mackSeen_d;
      sclPrev_q  <= sclF;
      sdaPrev_q  <= sdaF;
    end
  end

  assign SDA           = sdaOe_q ? 1'b0 : 1'bz;
  assign ram_wr_en_o   = wrEn_q;
  assign ram_wr_addr_o = wrAddr_q;
  assign ram_wr_data_o = wrData_q;
  assign ram_rd_en_o   = rdEn_q;
  assign ram_rd_addr_o = rdAddr_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_i2c_slave_sysclk_nb.sv
// Directed bench: bit-banged I2C master plus a one-cycle-latency RAM model
// around i2c_slave_sysclk_nb with default parameters (BYTES=4, ADDR_W=8).
module tb_i2c_slave_sysclk_nb;

  localparam int Q = 100;

  logic sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  logic rstN;
  logic scl;
  logic mLow;
  wire  sda;

  pullup (sda);
  assign sda = mLow ? 1'b0 : 1'bz;

  logic        ramWrEn;
  logic [7:0]  ramWrAddr;
  logic [31:0] ramWrData;
  logic        ramRdEn;
  logic [7:0]  ramRdAddr;
  logic [31:0] rdData;
  logic        busy;

  i2c_slave_sysclk_nb dut (
    .sys_clk_i     (sysClk),
    .rst_n_i       (rstN),
    .SCL           (scl),
    .SDA           (sda),
    .ram_wr_en_o   (ramWrEn),
    .ram_wr_addr_o (ramWrAddr),
    .ram_wr_data_o (ramWrData),
    .ram_rd_en_o   (ramRdEn),
    .ram_rd_addr_o (ramRdAddr),
    .ram_rd_data_i (rdData),
    .busy_o        (busy)
  );

  logic [31:0] mem [256];
  int wrCount = 0;
  int rdCount = 0;

  always @(posedge sysClk) begin
    if (ramWrEn) begin
      mem[ramWrAddr] <= ramWrData;
      wrCount <= wrCount + 1;
    end
    if (ramRdEn) begin
      rdData  <= mem[ramRdAddr];
      rdCount <= rdCount + 1;
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic        busyAcc;
  int          wrBase, rdBase;
  logic [31:0] w0, w1;
  logic        ackBit;

  logic [7:0] s1Data  [8]  = '{8'hF0, 8'hF1, 8'hF2, 8'hF3, 8'h12, 8'h13, 8'h14, 8'h15};
  logic [7:0] preData [16] = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h44, 8'h44, 8'h44, 8'h44,
                               8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D};

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic sclLvl, input logic sdaLow);
    scl  = sclLvl;
    mLow = sdaLow;
    #Q;
  endtask

  task automatic clockBit(input logic b, output logic s);
    applyStimulus(1'b0, ~b);
    applyStimulus(1'b1, ~b);
    s = sda;
    busyAcc = busyAcc | busy;
    applyStimulus(1'b1, ~b);
    applyStimulus(1'b0, ~b);
  endtask

  task automatic i2cStart();
    applyStimulus(scl, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
  endtask

  task automatic i2cStop();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
  endtask

  task automatic writeByte(input logic [7:0] b, input logic expSda, input string tag);
    logic s;
    for (int i = 7; i >= 0; i--) clockBit(b[i], s);
    clockBit(1'b1, s);
    checkOutput(tag, {63'd0, s}, {63'd0, expSda});
  endtask

  task automatic readByte(input logic mAck, output logic [7:0] b);
    logic s;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      clockBit(1'b1, s);
      b = {b[6:0], s};
    end
    clockBit(!mAck, s);
  endtask

  task automatic readWord(input logic lastNack, output logic [31:0] w);
    logic [7:0] b;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      readByte(!(lastNack && i == 3), b);
      w = {w[23:0], b};
    end
  endtask

  initial begin
    scl     = 1'b1;
    mLow    = 1'b0;
    rstN    = 1'b0;
    busyAcc = 1'b0;
    repeat (4) @(negedge sysClk);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_wr_en", {63'd0, ramWrEn}, 64'd0);
    checkOutput("rst_rd_en", {63'd0, ramRdEn}, 64'd0);
    checkOutput("rst_wr_addr", {56'd0, ramWrAddr}, 64'd0);
    checkOutput("rst_wr_data", {32'd0, ramWrData}, 64'd0);
    checkOutput("rst_rd_addr", {56'd0, ramRdAddr}, 64'd0);
    checkOutput("rst_sda", {63'd0, sda}, 64'd1);
    rstN = 1'b1;
    repeat (20) @(negedge sysClk);

    $display("[TB] write two words at pointer 00");
    i2cStart();
    writeByte(8'h4E, 1'b0, "s1_adr_ack");
    checkOutput("s1_busy", {63'd0, busy}, 64'd1);
    writeByte(8'h00, 1'b0, "s1_ptr_ack");
    for (int i = 0; i < 8; i++) writeByte(s1Data[i], 1'b0, $sformatf("s1_d%0d_ack", i));
    i2cStop();
    checkOutput("s1_busy_stop", {63'd0, busy}, 64'd0);
    checkOutput("s1_wr_count", 64'(wrCount), 64'd2);
    checkOutput("s1_ram0", {32'd0, mem[0]}, 64'hF0F1F2F3);
    checkOutput("s1_ram1", {32'd0, mem[1]}, 64'h12131415);

    $display("[TB] preload words 03..06");
    i2cStart();
    writeByte(8'h4E, 1'b0, "pre_adr_ack");
    writeByte(8'h03, 1'b0, "pre_ptr_ack");
    for (int i = 0; i < 16; i++) writeByte(preData[i], 1'b0, $sformatf("pre_d%0d_ack", i));
    i2cStop();
    checkOutput("pre_wr_count", 64'(wrCount), 64'd6);
    checkOutput("pre_ram5", {32'd0, mem[5]}, 64'hDEADBEEF);

    $display("[TB] pointer 00, repeated start, read 8 bytes");
    rdBase = rdCount;
    i2cStart();
    writeByte(8'h4E, 1'b0, "s2_adr_w_ack");
    writeByte(8'h00, 1'b0, "s2_ptr_ack");
    i2cStart();
    writeByte(8'h4F, 1'b0, "s2_adr_r_ack");
    checkOutput("s2_rd_first", 64'(rdCount - rdBase), 64'd1);
    readWord(1'b0, w0);
    checkOutput("s2_rd_before_nack", 64'(rdCount - rdBase), 64'd2);
    readWord(1'b1, w1);
    checkOutput("s2_busy_nack", {63'd0, busy}, 64'd0);
    i2cStop();
    checkOutput("s2_word0", {32'd0, w0}, 64'hF0F1F2F3);
    checkOutput("s2_word1", {32'd0, w1}, 64'h12131415);
    checkOutput("s2_rd_total", 64'(rdCount - rdBase), 64'd2);

    $display("[TB] wrong address 21h");
    wrBase  = wrCount;
    rdBase  = rdCount;
    busyAcc = 1'b0;
    i2cStart();
    writeByte(8'h42, 1'b1, "s3_adr_nack");
    writeByte(8'h00, 1'b1, "s3_ignored_nack");
    i2cStop();
    checkOutput("s3_busy_never", {63'd0, busyAcc}, 64'd0);
    checkOutput("s3_no_wr", 64'(wrCount - wrBase), 64'd0);
    checkOutput("s3_no_rd", 64'(rdCount - rdBase), 64'd0);

    $display("[TB] partial word at pointer 05 then reads");
    wrBase = wrCount;
    i2cStart();
    writeByte(8'h4E, 1'b0, "s5_adr_ack");
    writeByte(8'h05, 1'b0, "s5_ptr_ack");
    writeByte(8'h77, 1'b0, "s5_d0_ack");
    writeByte(8'h88, 1'b0, "s5_d1_ack");
    writeByte(8'h99, 1'b0, "s5_d2_ack");
    i2cStop();
    checkOutput("s5_no_wr", 64'(wrCount - wrBase), 64'd0);
    i2cStart();
    writeByte(8'h4E, 1'b0, "s5_adr_w2_ack");
    writeByte(8'h05, 1'b0, "s5_ptr2_ack");
    i2cStart();
    writeByte(8'h4F, 1'b0, "s5_adr_r_ack");
    readWord(1'b1, w0);
    i2cStop();
    checkOutput("s5_old_ram5", {32'd0, w0}, 64'hDEADBEEF);
    i2cStart();
    writeByte(8'h4F, 1'b0, "s5_adr_r2_ack");
    readWord(1'b1, w1);
    i2cStop();
    checkOutput("s5_persist_ram6", {32'd0, w1}, 64'h0BADF00D);

    $display("[TB] pointer FF wrap");
    wrBase = wrCount;
    i2cStart();
    writeByte(8'h4E, 1'b0, "s4_adr_ack");
    writeByte(8'hFF, 1'b0, "s4_ptr_ack");
    for (int i = 0; i < 8; i++) writeByte(8'hA0 + 8'(i), 1'b0, $sformatf("s4_d%0d_ack", i));
    i2cStop();
    checkOutput("s4_wr_count", 64'(wrCount - wrBase), 64'd2);
    checkOutput("s4_ramFF", {32'd0, mem[255]}, 64'hA0A1A2A3);
    checkOutput("s4_ram00", {32'd0, mem[0]}, 64'hA4A5A6A7);

    $display("[TB] reset during third data byte");
    wrBase = wrCount;
    i2cStart();
    writeByte(8'h4E, 1'b0, "s6_adr_ack");
    writeByte(8'h03, 1'b0, "s6_ptr_ack");
    writeByte(8'hC1, 1'b0, "s6_d0_ack");
    writeByte(8'hC2, 1'b0, "s6_d1_ack");
    clockBit(1'b1, ackBit);
    clockBit(1'b0, ackBit);
    clockBit(1'b1, ackBit);
    clockBit(1'b1, ackBit);
    checkOutput("s6_busy_pre", {63'd0, busy}, 64'd1);
    rstN = 1'b0;
    repeat (2) @(negedge sysClk);
    checkOutput("s6_sda_rst", {63'd0, sda}, 64'd1);
    checkOutput("s6_busy_rst", {63'd0, busy}, 64'd0);
    checkOutput("s6_wr_en_rst", {63'd0, ramWrEn}, 64'd0);
    rstN = 1'b1;
    repeat (4) @(negedge sysClk);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("s6_no_wr", 64'(wrCount - wrBase), 64'd0);
    i2cStart();
    writeByte(8'h4F, 1'b0, "s6_adr_r_ack");
    readWord(1'b1, w0);
    i2cStop();
    checkOutput("s6_ptr_zero_read", {32'd0, w0}, 64'hA4A5A6A7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
